// File: rtl/seg7_text_scroller.sv
// Multi-bank 7-segment text engine: appends characters to a buffer and scans them onto BANKS x 4 digits.
// Display outputs are registered one cycle behind the scan index; writes beyond capacity raise a 1-cycle overflow pulse.
module seg7_text_scroller #(
  parameter int BANKS       = 2,
  parameter int BUF_DEPTH   = 16,
  parameter int REFRESH_DIV = 50000,
  parameter int SCROLL_DIV  = 25000000
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       wr_en_i,
  input  logic [6:0]                 wr_char_i,
  input  logic                       clear_i,
  input  logic [1:0]                 mode_i,
  input  logic                       pause_i,
  output logic [7*BANKS-1:0]         segdata_o,
  output logic [4*BANKS-1:0]         segsele_o,
  output logic [BANKS-1:0]           segdp_o,
  output logic [$clog2(BUF_DEPTH):0] count_o,
  output logic                       full_o,
  output logic                       overflow_o
);

  localparam int NDIG = 4 * BANKS;
  localparam int AW   = $clog2(BUF_DEPTH);
  localparam int CW   = AW + 1;
  localparam int PW   = CW + 1;
  localparam int RW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_STATIC,
    ST_SCROLL,
    ST_BLINK
  } state_t;

  state_t               state_q, state_d;
  logic [6:0]           mem [BUF_DEPTH];
  logic [CW-1:0]        count_q;
  logic                 ovf_q;
  logic [RW-1:0]        ref_q;
  logic [1:0]           dig_q;
  logic [SW-1:0]        sc_q;
  logic [AW-1:0]        offset_q;
  logic                 phase_q;
  logic [4*BANKS-1:0]   sele_q, sele_d;
  logic [7*BANKS-1:0]   seg_q, seg_d;
  logic [BANKS-1:0]     dp_q, dp_d;

  logic                 full;
  logic                 wr_ok;
  logic                 ref_wrap;
  logic                 tick;
  logic                 mode_chg;
  logic                 long_text;
  logic [AW-1:0]        offset_nxt;
  logic [PW-1:0]        pos_c;
  logic [PW-1:0]        idx_c;
  logic [6:0]           chr_c;
  logic                 show_c;

  function automatic logic [6:0] glyph(input logic [5:0] c);
    // bit 0 = segment a ... bit 6 = segment g
    case (c)
      6'd0:  glyph = 7'h3F;  6'd1:  glyph = 7'h06;  6'd2:  glyph = 7'h5B;  6'd3:  glyph = 7'h4F;
      6'd4:  glyph = 7'h66;  6'd5:  glyph = 7'h6D;  6'd6:  glyph = 7'h7D;  6'd7:  glyph = 7'h07;
      6'd8:  glyph = 7'h7F;  6'd9:  glyph = 7'h6F;  6'd10: glyph = 7'h77;  6'd11: glyph = 7'h7C;
      6'd12: glyph = 7'h39;  6'd13: glyph = 7'h5E;  6'd14: glyph = 7'h79;  6'd15: glyph = 7'h71;
      6'd16: glyph = 7'h3D;  6'd17: glyph = 7'h76;  6'd18: glyph = 7'h30;  6'd19: glyph = 7'h1E;
      6'd20: glyph = 7'h75;  6'd21: glyph = 7'h38;  6'd22: glyph = 7'h37;  6'd23: glyph = 7'h54;
      6'd24: glyph = 7'h5C;  6'd25: glyph = 7'h73;  6'd26: glyph = 7'h67;  6'd27: glyph = 7'h50;
      6'd28: glyph = 7'h6D;  6'd29: glyph = 7'h78;  6'd30: glyph = 7'h3E;  6'd31: glyph = 7'h1C;
      6'd32: glyph = 7'h2A;  6'd33: glyph = 7'h49;  6'd34: glyph = 7'h6E;  6'd35: glyph = 7'h5B;
      6'd37: glyph = 7'h40;
      default: glyph = 7'h00;
    endcase
  endfunction

  assign full       = (count_q == CW'(BUF_DEPTH));
  assign wr_ok      = wr_en_i && !full && !clear_i;
  assign ref_wrap   = (ref_q == RW'(REFRESH_DIV - 1));
  assign tick       = !pause_i && (sc_q == SW'(SCROLL_DIV - 1));
  assign long_text  = (count_q > CW'(NDIG));
  assign offset_nxt = ((CW'(offset_q) + CW'(1)) >= count_q) ? '0 : offset_q + AW'(1);
  assign mode_chg   = (state_d != state_q);

  always_comb begin
    state_d = ST_EMPTY;
    if (count_q != '0) begin
      case (mode_i)
        2'b01:   state_d = ST_SCROLL;
        2'b10:   state_d = ST_BLINK;
        default: state_d = ST_STATIC;
      endcase
    end
  end

  // Every bank decodes the same scan index; bank b digit d is logical position 4b+d.
  always_comb begin
    sele_d = '0;
    seg_d  = '0;
    dp_d   = '0;
    pos_c  = '0;
    idx_c  = '0;
    chr_c  = '0;
    show_c = 1'b0;
    for (int b = 0; b < BANKS; b++) begin
      sele_d[4*b +: 4] = 4'b0001 << dig_q;
      pos_c = PW'(4 * b) + PW'(dig_q);
      idx_c = pos_c;
      if (state_q == ST_SCROLL && long_text) begin
        idx_c = pos_c + PW'(offset_q);
        if (idx_c >= PW'(count_q)) idx_c = idx_c - PW'(count_q);
      end
      chr_c  = mem[idx_c[AW-1:0]];
      show_c = (state_q != ST_EMPTY) && (idx_c < PW'(count_q)) &&
               !(state_q == ST_BLINK && !phase_q);
      if (show_c) begin
        seg_d[7*b +: 7] = glyph(chr_c[5:0]);
        dp_d[b]         = chr_c[6];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[count_q[AW-1:0]] <= wr_char_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_EMPTY;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ref_q    <= '0;
      dig_q    <= '0;
      sc_q     <= '0;
      offset_q <= '0;
      phase_q  <= 1'b1;
      sele_q   <= '0;
      seg_q    <= '0;
      dp_q     <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= wr_en_i && full && !clear_i;
      if (clear_i)    count_q <= '0;
      else if (wr_ok) count_q <= count_q + CW'(1);

      if (ref_wrap) begin
        ref_q <= '0;
        dig_q <= dig_q + 2'd1;
      end else begin
        ref_q <= ref_q + RW'(1);
      end

      if (mode_chg) begin
        sc_q     <= '0;
        offset_q <= '0;
        phase_q  <= 1'b1;
      end else begin
        if (!pause_i) sc_q <= tick ? '0 : sc_q + SW'(1);
        if (tick && state_q == ST_SCROLL) offset_q <= long_text ? offset_nxt : '0;
        if (tick && state_q == ST_BLINK)  phase_q  <= !phase_q;
      end
      if (clear_i) offset_q <= '0;

      sele_q <= sele_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign segdata_o  = seg_q;
  assign segsele_o  = sele_q;
  assign segdp_o    = dp_q;
  assign count_o    = count_q;
  assign full_o     = full;
  assign overflow_o = ovf_q;

endmodule
